// File: rtl/ps2_key_fifo.sv
// PS/2 scan-code assembler and FIFO: folds E0/F0 prefixes into ext/break flags
// and queues completed codes first-word-fall-through for a consumer.
module ps2_key_fifo #(
  parameter int DEPTH      = 16,
  parameter int KEEP_BREAK = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     key_pressed,
  input  logic [7:0]               key_data,
  input  logic                     rd_en,
  input  logic                     clr,
  output logic                     out_valid,
  output logic [7:0]               out_code,
  output logic                     out_ext,
  output logic                     out_break,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // state   | meaning
  // IDLE    | no prefix pending
  // EXT     | E0 seen
  // BRK     | F0 seen
  // EXT_BRK | both E0 and F0 seen
  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;

  state_t          state, state_nx;
  logic            done, done_ext, done_brk;
  logic            is_e0, is_f0;
  logic            live, want, pop, push, drop;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [9:0]      mem [DEPTH];
  logic [9:0]      head;

  assign is_e0 = (key_data == 8'hE0);
  assign is_f0 = (key_data == 8'hF0);

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    done_ext = 1'b0;
    done_brk = 1'b0;
    if (key_pressed) begin
      case (state)
        IDLE: begin
          if (is_e0)      state_nx = EXT;
          else if (is_f0) state_nx = BRK;
          else            done     = 1'b1;
        end
        EXT: begin
          if (is_f0)      state_nx = EXT_BRK;
          else if (!is_e0) begin
            done     = 1'b1;
            done_ext = 1'b1;
            state_nx = IDLE;
          end
        end
        BRK: begin
          if (is_e0)      state_nx = EXT_BRK;
          else if (!is_f0) begin
            done     = 1'b1;
            done_brk = 1'b1;
            state_nx = IDLE;
          end
        end
        default: begin
          if (!is_e0 && !is_f0) begin
            done     = 1'b1;
            done_ext = 1'b1;
            done_brk = 1'b1;
            state_nx = IDLE;
          end
        end
      endcase
    end
  end

  // clr and reset share one flush path; gating push keeps storage untouched too
  assign live      = resetn && !clr;
  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign want      = live && done && ((KEEP_BREAK != 0) || !done_brk);
  assign pop       = live && rd_en && out_valid;
  assign push      = want && (!full || pop);
  assign drop      = want && full && !pop;

  always_ff @(posedge clock) begin
    if (!resetn || clr) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {key_data, done_ext, done_brk};
  end

  assign head      = mem[rd_ptr];
  assign out_code  = out_valid ? head[9:2] : 8'h00;
  assign out_ext   = out_valid & head[1];
  assign out_break = out_valid & head[0];

endmodule

// File: doc/ps2_key_fifo.md
PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count, power of two, 2..256.
REQ-002 SHALL have parameter KEEP_BREAK, default 0: 0 = discard key-release codes, 1 = store them with out_break=1.
REQ-003 SHALL have port clock  input  1  sole clock, all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port key_pressed  input  1  one-cycle strobe, one per received PS/2 byte.
REQ-006 SHALL have port key_data  input  8  received PS/2 byte, valid when key_pressed=1.
REQ-007 SHALL have port rd_en  input  1  consumer pop request.
REQ-008 SHALL have port clr  input  1  synchronous flush of FIFO, prefix state and overflow.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_code  output  8  head scan code.
REQ-011 SHALL have port out_ext  output  1  head carried E0 prefix.
REQ-012 SHALL have port out_break  output  1  head carried F0 prefix (release).
REQ-013 SHALL have port count  output  clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-014 SHALL have port full  output  1  count==DEPTH.
REQ-015 SHALL have port overflow  output  1  sticky: a completed code was dropped while full.

Function
REQ-016 SHALL run a prefix FSM with states IDLE, EXT, BRK, EXT_BRK, advancing only on cycles with key_pressed=1.
REQ-017 SHALL transition IDLE: E0->EXT; F0->BRK; other byte->complete code {ext=0,brk=0}, stay IDLE.
REQ-018 SHALL transition EXT: F0->EXT_BRK; E0->EXT; other->complete code {ext=1,brk=0}, ->IDLE.
REQ-019 SHALL transition BRK: F0->BRK; E0->EXT_BRK; other->complete code {ext=0,brk=1}, ->IDLE.
REQ-020 SHALL transition EXT_BRK: E0 or F0->EXT_BRK; other->complete code {ext=1,brk=1}, ->IDLE.
REQ-021 SHALL never store E0/F0 prefix bytes; all other byte values, including E1 and AA, are ordinary codes.
REQ-022 SHALL, with KEEP_BREAK=0, discard completed codes with brk=1 (no push, no overflow effect).
REQ-023 SHALL push a completed code on the same edge the final byte is strobed; out_valid rises the next cycle when previously empty (1-cycle latency).
REQ-024 SHALL be first-word-fall-through: out_code/out_ext/out_break show the head whenever out_valid=1, and are 0 when out_valid=0.
REQ-025 SHALL pop on rd_en=1 and out_valid=1; rd_en while empty has no effect.
REQ-026 SHALL accept a push while full only if a pop occurs the same cycle (count unchanged, order preserved).
REQ-027 SHALL drop a push while full with no pop, leave contents unchanged, and set overflow=1.
REQ-028 SHALL update count by +1 (push only), -1 (pop only), 0 (both or neither) in the same edge.
REQ-029 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-030 SHALL give clr priority over push and pop in the same cycle: count=0, out_valid=0, overflow=0, FSM=IDLE, incoming byte discarded.

Reset
REQ-031 SHALL, on resetn=0 at a rising edge, set out_valid=0, out_code=0, out_ext=0, out_break=0, count=0, full=0, overflow=0, FSM=IDLE, pointers=0.
REQ-032 SHALL discard any partially received prefix sequence on reset; storage contents need not be cleared.
REQ-033 SHALL ignore key_pressed, rd_en and clr while resetn=0.

Verification
REQ-034 SHALL cover: bytes 1C, then E0 75 -> entries {1C,ext0,brk0}, {75,ext1,brk0}; out_valid high the cycle after 1C strobe.
REQ-035 SHALL cover: KEEP_BREAK=0, bytes F0 1C, E0 F0 75 -> count stays 0; KEEP_BREAK=1 -> entries {1C,0,1}, {75,1,1}.
REQ-036 SHALL cover: DEPTH=4, push 5 codes with no reads -> full=1, count=4, overflow=1, reads return first 4 in order.
REQ-037 SHALL cover: full FIFO, simultaneous push and rd_en -> count stays 4, overflow stays 0, new code read last.
REQ-038 SHALL cover: 3*DEPTH interleaved push/pop codes 00..2F -> read order 00..2F exactly (pointer wrap).
REQ-039 SHALL cover: E0 strobed, then resetn=0 one cycle, then 1C -> single entry {1C,ext0,brk0}; same with clr instead of reset.
